// File: rtl/alu_stage_pkg.sv
// Shared types and constants for the ALU operand sequencing stage.
package alu_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_PARITY  = 2'b10;

  localparam int OPW_DEF = 4;

endpackage

// File: rtl/alu_operand_stage_operand_reg.sv
// Width-parameterised flip-flop register with load enable and synchronous reset.
module operand_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Serialising operand/result stage in front of the ALU: accept, start, wait/timeout, hold.
// Optional input parity checking is enabled with the ALU_IN_PARITY_EN macro.
module alu_operand_stage
  import alu_stage_pkg::*;
#(
  parameter int W       = 8,
  parameter int OPW     = OPW_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic           CLK,
  input  logic           RST,
`ifdef ALU_IN_PARITY_EN
  input  logic           IN_PARITY,
`endif
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [W-1:0]   IN_A,
  input  logic [W-1:0]   IN_B,
  input  logic [OPW-1:0] IN_OP,
  output logic           ALU_START,
  output logic [W-1:0]   ALU_A,
  output logic [W-1:0]   ALU_B,
  output logic [OPW-1:0] ALU_OP,
  input  logic           ALU_DONE,
  input  logic [2*W-1:0] ALU_RESULT,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [2*W-1:0] OUT_RESULT,
  output logic [1:0]     OUT_ERR,
  output logic           BUSY
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           accept;
  logic           par_err;
  logic           res_load;
  logic [2*W-1:0] res_d;
  logic [1:0]     err_d;

  assign accept = IN_VALID && (state_q == ST_IDLE);

`ifdef ALU_IN_PARITY_EN
  // Even parity: the parity bit equals the XOR of all covered bits.
  assign par_err = IN_PARITY != (^{IN_OP, IN_B, IN_A});
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_load = 1'b0;
    res_d    = '0;
    err_d    = ERR_OK;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (par_err) begin
            state_d  = ST_HOLD;
            res_load = 1'b1;
            err_d    = ERR_PARITY;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = CW'(1);
        if (ALU_DONE) begin
          res_load = 1'b1;
          res_d    = ALU_RESULT;
          state_d  = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
        // The cycle where the count reaches TIMEOUT still honours a coincident done.
        if (ALU_DONE) begin
          res_load = 1'b1;
          res_d    = ALU_RESULT;
          state_d  = ST_HOLD;
        end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
          res_load = 1'b1;
          err_d    = ERR_TIMEOUT;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  operand_reg #(.WIDTH(W)) u_a_reg (
    .clk(CLK), .rst(RST), .load(accept), .d(IN_A), .q(ALU_A)
  );

  operand_reg #(.WIDTH(W)) u_b_reg (
    .clk(CLK), .rst(RST), .load(accept), .d(IN_B), .q(ALU_B)
  );

  operand_reg #(.WIDTH(OPW)) u_op_reg (
    .clk(CLK), .rst(RST), .load(accept), .d(IN_OP), .q(ALU_OP)
  );

  operand_reg #(.WIDTH(2*W)) u_res_reg (
    .clk(CLK), .rst(RST), .load(res_load), .d(res_d), .q(OUT_RESULT)
  );

  operand_reg #(.WIDTH(2)) u_err_reg (
    .clk(CLK), .rst(RST), .load(res_load), .d(err_d), .q(OUT_ERR)
  );

  // Pure state decodes: no combinational path from any input.
  assign IN_READY  = (state_q == ST_IDLE);
  assign ALU_START = (state_q == ST_ISSUE);
  assign OUT_VALID = (state_q == ST_HOLD);
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage (optional ALU_IN_PARITY_EN section).
module tb_alu_operand_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IN_A;
  logic [7:0]  IN_B;
  logic [3:0]  IN_OP;
  logic        ALU_START;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_OP;
  logic        ALU_DONE;
  logic [15:0] ALU_RESULT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT_RESULT;
  logic [1:0]  OUT_ERR;
  logic        BUSY;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;

`ifdef ALU_IN_PARITY_EN
  logic par_flip = 1'b0;
  logic IN_PARITY;
  assign IN_PARITY = par_flip ^ (^{IN_OP, IN_B, IN_A});
`endif

  alu_operand_stage #(.W(8), .OPW(4), .TIMEOUT(16)) dut (
    .CLK(CLK),
    .RST(RST),
`ifdef ALU_IN_PARITY_EN
    .IN_PARITY(IN_PARITY),
`endif
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .IN_A(IN_A),
    .IN_B(IN_B),
    .IN_OP(IN_OP),
    .ALU_START(ALU_START),
    .ALU_A(ALU_A),
    .ALU_B(ALU_B),
    .ALU_OP(ALU_OP),
    .ALU_DONE(ALU_DONE),
    .ALU_RESULT(ALU_RESULT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_RESULT(OUT_RESULT),
    .OUT_ERR(OUT_ERR),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (ALU_START === 1'b1) start_cnt++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  32'(IN_READY),   32'h1);
    check({tag, ".alu_start"}, 32'(ALU_START),  32'h0);
    check({tag, ".alu_a"},     32'(ALU_A),      32'h0);
    check({tag, ".alu_b"},     32'(ALU_B),      32'h0);
    check({tag, ".alu_op"},    32'(ALU_OP),     32'h0);
    check({tag, ".out_valid"}, 32'(OUT_VALID),  32'h0);
    check({tag, ".out_result"},32'(OUT_RESULT), 32'h0);
    check({tag, ".out_err"},   32'(OUT_ERR),    32'h0);
    check({tag, ".busy"},      32'(BUSY),       32'h0);
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; IN_OP = '0;
    ALU_DONE = 1'b0; ALU_RESULT = '0; OUT_READY = 1'b0;
    tick(); tick();
    RST = 1'b0;
    check_reset_outputs("reset");

    // Op 1: done returned in the ISSUE cycle.
    IN_A = 8'h0F; IN_B = 8'h03; IN_OP = 4'h2; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    check("op1.start",    32'(ALU_START), 32'h1);
    check("op1.alu_a",    32'(ALU_A),     32'h0F);
    check("op1.alu_b",    32'(ALU_B),     32'h03);
    check("op1.alu_op",   32'(ALU_OP),    32'h2);
    check("op1.in_ready", 32'(IN_READY),  32'h0);
    check("op1.busy",     32'(BUSY),      32'h1);
    check("op1.valid_early", 32'(OUT_VALID), 32'h0);
    ALU_DONE = 1'b1; ALU_RESULT = 16'h002D;
    tick();
    ALU_DONE = 1'b0; ALU_RESULT = 16'h0000;
    check("op1.start_off", 32'(ALU_START),  32'h0);
    check("op1.out_valid", 32'(OUT_VALID),  32'h1);
    check("op1.result",    32'(OUT_RESULT), 32'h002D);
    check("op1.err",       32'(OUT_ERR),    32'h0);
    check("op1.start_cnt", 32'(start_cnt),  32'd1);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("op1.idle_ready", 32'(IN_READY),  32'h1);
    check("op1.idle_valid", 32'(OUT_VALID), 32'h0);

    // Op 2: done delayed, consumer stalls for 3 cycles.
    IN_A = 8'hAA; IN_B = 8'h55; IN_OP = 4'h5; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("op2.wait_valid", 32'(OUT_VALID), 32'h0);
      check("op2.wait_ready", 32'(IN_READY),  32'h0);
      tick();
    end
    ALU_DONE = 1'b1; ALU_RESULT = 16'h1234;
    tick();
    ALU_DONE = 1'b0; ALU_RESULT = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      check("op2.hold_valid",  32'(OUT_VALID),  32'h1);
      check("op2.hold_result", 32'(OUT_RESULT), 32'h1234);
      check("op2.hold_err",    32'(OUT_ERR),    32'h0);
      check("op2.hold_ready",  32'(IN_READY),   32'h0);
      check("op2.hold_alu_a",  32'(ALU_A),      32'hAA);
      tick();
    end
    // Handshake cycle: offered input must not be taken yet.
    IN_A = 8'h11; IN_B = 8'h22; IN_OP = 4'h3; IN_VALID = 1'b1; OUT_READY = 1'b1;
    check("op2.hs_ready", 32'(IN_READY), 32'h0);
    tick();
    OUT_READY = 1'b0;
    check("op2.post_ready", 32'(IN_READY),  32'h1);
    check("op2.post_valid", 32'(OUT_VALID), 32'h0);
    check("op2.post_busy",  32'(BUSY),      32'h0);
    check("op2.post_alu_a", 32'(ALU_A),     32'hAA);

    // Op 3: accepted back-to-back, done never arrives -> timeout.
    tick();
    IN_VALID = 1'b0;
    check("op3.start", 32'(ALU_START), 32'h1);
    check("op3.alu_a", 32'(ALU_A),     32'h11);
    for (int i = 0; i < 15; i++) tick();
    check("op3.pre_timeout_valid", 32'(OUT_VALID), 32'h0);
    check("op3.pre_timeout_busy",  32'(BUSY),      32'h1);
    tick();
    check("op3.timeout_valid",  32'(OUT_VALID),  32'h1);
    check("op3.timeout_err",    32'(OUT_ERR),    32'h1);
    check("op3.timeout_result", 32'(OUT_RESULT), 32'h0);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;

    // Op 4: done coincides with the timeout cycle; done wins.
    IN_A = 8'h01; IN_B = 8'h02; IN_OP = 4'h1; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    ALU_DONE = 1'b1; ALU_RESULT = 16'hBEEF;
    tick();
    ALU_DONE = 1'b0; ALU_RESULT = 16'h0000;
    check("op4.valid",  32'(OUT_VALID),  32'h1);
    check("op4.err",    32'(OUT_ERR),    32'h0);
    check("op4.result", 32'(OUT_RESULT), 32'hBEEF);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;

    // Op 5: reset while waiting, then a late done.
    IN_A = 8'h77; IN_B = 8'h66; IN_OP = 4'h9; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick(); tick();
    check("op5.waiting_busy", 32'(BUSY), 32'h1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_reset_outputs("op5.reset");
    ALU_DONE = 1'b1; ALU_RESULT = 16'hCAFE;
    tick();
    ALU_DONE = 1'b0;
    tick();
    check("op5.late_valid",  32'(OUT_VALID),  32'h0);
    check("op5.late_result", 32'(OUT_RESULT), 32'h0);
    check("op5.late_ready",  32'(IN_READY),   32'h1);
    check("op5.start_cnt",   32'(start_cnt),  32'd5);

`ifdef ALU_IN_PARITY_EN
    // Op 6: corrupted parity goes straight to HOLD with no start pulse.
    IN_A = 8'h0F; IN_B = 8'h03; IN_OP = 4'h2; par_flip = 1'b1; IN_VALID = 1'b1;
    check("op6.parity_bit", 32'(IN_PARITY), 32'h0);
    tick();
    IN_VALID = 1'b0; par_flip = 1'b0;
    check("op6.start",     32'(ALU_START),  32'h0);
    check("op6.valid",     32'(OUT_VALID),  32'h1);
    check("op6.err",       32'(OUT_ERR),    32'h2);
    check("op6.result",    32'(OUT_RESULT), 32'h0);
    tick();
    check("op6.start_cnt", 32'(start_cnt),  32'd5);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("op6.idle", 32'(IN_READY), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
